// File: rtl/sha2_pkg.sv
// -----------------------------------------------------------------------------
// sha2_pkg
//   Shared definitions for the SHA-2 sigma pipeline:
//     - sigma_mode_e : operand mode encodings (BSIG0, BSIG1, SSIG0, SSIG1)
//     - AMT32/AMT64  : per-mode amounts of the three terms for 32/64-bit words
//     - sigma_term() : returns amount and shift-vs-rotate flag of one term
//   The third term of the small sigmas (SSIG0/SSIG1) is a logical shift;
//   every other term is a cyclic rotation.
// -----------------------------------------------------------------------------
package sha2_pkg;

    typedef enum logic [1:0] {
        SIGMA_BSIG0 = 2'd0,
        SIGMA_BSIG1 = 2'd1,
        SIGMA_SSIG0 = 2'd2,
        SIGMA_SSIG1 = 2'd3
    } sigma_mode_e;

    typedef struct packed {
        logic [6:0] amt;     // rotate/shift distance
        logic       is_shr;  // 1: logical shift right, 0: rotate right
    } sigma_term_t;

    // Rows indexed by mode, columns by term index.
    localparam int AMT32 [4][3] = '{
        '{ 2, 13, 22},
        '{ 6, 11, 25},
        '{ 7, 18,  3},
        '{17, 19, 10}
    };

    localparam int AMT64 [4][3] = '{
        '{28, 34, 39},
        '{14, 18, 41},
        '{ 1,  8,  7},
        '{19, 61,  6}
    };

    function automatic sigma_term_t sigma_term(input int width,
                                               input logic [1:0] mode,
                                               input int idx);
        sigma_term_t t;
        if (width == 64) begin
            t.amt = 7'(AMT64[mode][idx]);
        end else begin
            t.amt = 7'(AMT32[mode][idx]);
        end
        // Modes 2 and 3 (small sigmas) use SHR for their last term.
        t.is_shr = mode[1] && (idx == 2);
        return t;
    endfunction

endpackage

// File: rtl/sha2_rotr.sv
// -----------------------------------------------------------------------------
// sha2_rotr
//   Pure combinational rotate-right of a W-bit word by the constant N.
//   Ports:
//     data_i  in  W  word to rotate
//     data_o  out W  data_i rotated right by N (N in 1..W-1)
// -----------------------------------------------------------------------------
module sha2_rotr #(
    parameter int W = 32,
    parameter int N = 1
) (
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o
);

    assign data_o = {data_i[N-1:0], data_i[W-1:N]};

endmodule

// File: rtl/sha2_sigma_pipe.sv
// -----------------------------------------------------------------------------
// sha2_sigma_pipe
//   Two-stage pipelined SHA-2 sigma unit (BSIG0/BSIG1/SSIG0/SSIG1) for 32-bit
//   (SHA-256) or 64-bit (SHA-512) words, with valid/ready on both sides and an
//   opaque tag carried alongside each operand.
//     Stage 1 registers the three mode-selected terms and the tag.
//     Stage 2 registers their XOR as the result.
//   Ports:
//     clk        in   1       rising-edge clock
//     rst        in   1       asynchronous reset, active-high
//     in_valid   in   1       operand valid
//     in_ready   out  1       operand accepted this cycle (combinational from out_ready)
//     in_mode    in   2       0=BSIG0 1=BSIG1 2=SSIG0 3=SSIG1
//     in_data    in   WORD_W  operand word
//     in_tag     in   TAG_W   tag returned with the result
//     out_valid  out  1       result valid
//     out_ready  in   1       downstream accepts result
//     out_data   out  WORD_W  sigma result
//     out_tag    out  TAG_W   tag of the result
//     out_parity out  1       XOR-reduce of out_data (only with SHA2_SIGMA_PARITY_EN)
//   Build option: define SHA2_SIGMA_PARITY_EN to add the out_parity port.
// -----------------------------------------------------------------------------
module sha2_sigma_pipe
    import sha2_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_mode,
    input  logic [WORD_W-1:0] in_data,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag
`ifdef SHA2_SIGMA_PARITY_EN
    ,
    output logic              out_parity
`endif
);

    genvar gi, gj;

    if (WORD_W != 32 && WORD_W != 64) begin : g_bad_width
        $error("sha2_sigma_pipe: WORD_W must be 32 or 64");
    end

    // -------------------------------------------------------------------------
    // Term generation: every term of every mode is built in parallel from
    // constant rotators; SHR terms are a rotation with the wrapped bits masked.
    // -------------------------------------------------------------------------
    logic [WORD_W-1:0] term_w [4][3];

    for (gi = 0; gi < 4; gi++) begin : g_mode
        for (gj = 0; gj < 3; gj++) begin : g_term
            localparam sigma_term_t TERM = sigma_term(WORD_W, 2'(gi), gj);
            localparam logic [WORD_W-1:0] KEEP =
                TERM.is_shr ? ({WORD_W{1'b1}} >> TERM.amt) : {WORD_W{1'b1}};

            logic [WORD_W-1:0] rot_w;

            sha2_rotr #(
                .W (WORD_W),
                .N (int'(TERM.amt))
            ) u_rotr (
                .data_i (in_data),
                .data_o (rot_w)
            );

            assign term_w[gi][gj] = rot_w & KEEP;
        end
    end

    // -------------------------------------------------------------------------
    // Handshake control
    // -------------------------------------------------------------------------
    logic s1_valid_q;
    logic s2_valid_q;
    logic adv1;
    logic adv2;

    assign adv2     = !s2_valid_q || out_ready;
    assign adv1     = !s1_valid_q || adv2;
    assign in_ready = adv1;

    // -------------------------------------------------------------------------
    // Stage 1: mode-selected terms and tag
    // -------------------------------------------------------------------------
    logic [WORD_W-1:0] t0_d, t1_d, t2_d;
    logic [WORD_W-1:0] t0_q, t1_q, t2_q;
    logic [TAG_W-1:0]  s1_tag_q;

    always_comb begin
        t0_d = term_w[in_mode][0];
        t1_d = term_w[in_mode][1];
        t2_d = term_w[in_mode][2];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            t0_q       <= '0;
            t1_q       <= '0;
            t2_q       <= '0;
            s1_tag_q   <= '0;
        end else if (adv1) begin
            s1_valid_q <= in_valid;
            // Payload only loads for a real operand; idle inputs are ignored.
            if (in_valid) begin
                t0_q     <= t0_d;
                t1_q     <= t1_d;
                t2_q     <= t2_d;
                s1_tag_q <= in_tag;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2: combined result; held while stalled
    // -------------------------------------------------------------------------
    logic [WORD_W-1:0] sum_d;
    logic [WORD_W-1:0] data_q;
    logic [TAG_W-1:0]  s2_tag_q;

    assign sum_d = t0_q ^ t1_q ^ t2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            data_q     <= '0;
            s2_tag_q   <= '0;
        end else if (adv2) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                data_q   <= sum_d;
                s2_tag_q <= s1_tag_q;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = data_q;
    assign out_tag   = s2_tag_q;

`ifdef SHA2_SIGMA_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else if (adv2 && s1_valid_q) begin
            parity_q <= ^sum_d;
        end
    end

    assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_sha2_sigma_pipe.sv
// -----------------------------------------------------------------------------
// tb_sha2_sigma_pipe
//   Directed bench for sha2_sigma_pipe with a 32-bit and a 64-bit instance.
//   Expected results are hand-computed constants in the vector tables.
// -----------------------------------------------------------------------------
module tb_sha2_sigma_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic        iv32, ir32, ov32, or32;
    logic [1:0]  im32;
    logic [31:0] id32, od32;
    logic [3:0]  it32, ot32;

    logic        iv64, ir64, ov64, or64;
    logic [1:0]  im64;
    logic [63:0] id64, od64;
    logic [3:0]  it64, ot64;

`ifdef SHA2_SIGMA_PARITY_EN
    logic        op32, op64;
`endif

    sha2_sigma_pipe #(.WORD_W(32), .TAG_W(4)) dut32 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv32),
        .in_ready  (ir32),
        .in_mode   (im32),
        .in_data   (id32),
        .in_tag    (it32),
        .out_valid (ov32),
        .out_ready (or32),
        .out_data  (od32),
        .out_tag   (ot32)
`ifdef SHA2_SIGMA_PARITY_EN
        ,
        .out_parity(op32)
`endif
    );

    sha2_sigma_pipe #(.WORD_W(64), .TAG_W(4)) dut64 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv64),
        .in_ready  (ir64),
        .in_mode   (im64),
        .in_data   (id64),
        .in_tag    (it64),
        .out_valid (ov64),
        .out_ready (or64),
        .out_data  (od64),
        .out_tag   (ot64)
`ifdef SHA2_SIGMA_PARITY_EN
        ,
        .out_parity(op64)
`endif
    );

    typedef struct {
        logic [1:0]  mode;
        logic [63:0] data;
        logic [3:0]  tag;
        logic [63:0] exp;
    } vec_t;

    typedef struct {
        logic [63:0] data;
        logic [3:0]  tag;
        int          cyc;
    } pend_t;

    vec_t  v32 [7];
    vec_t  v64 [4];
    pend_t q32 [$];
    pend_t q64 [$];

    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    int          nout32 = 0;
    int          nout64 = 0;
    bit          chk_lat = 1'b0;
    logic [63:0] exp32_cur, exp64_cur;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Called at a falling edge with inputs driven; records handshakes that
    // happen on the coming rising edge and checks outputs against the queues.
    task automatic step();
        pend_t p;
        #1;
        if (!rst) begin
            if (iv32 && ir32) q32.push_back('{exp32_cur, it32, cyc});
            if (iv64 && ir64) q64.push_back('{exp64_cur, it64, cyc});
            if (ov32 && or32) begin
                if (q32.size() == 0) begin
                    check("out32_unexpected", 64'(ot32), 64'hFFFF);
                end else begin
                    p = q32.pop_front();
                    check("out32_data", {32'b0, od32}, p.data);
                    check("out32_tag", 64'(ot32), 64'(p.tag));
                    if (chk_lat) check("out32_latency", 64'(cyc - p.cyc), 64'd2);
`ifdef SHA2_SIGMA_PARITY_EN
                    check("out32_parity", 64'(op32), 64'(^p.data));
`endif
                    nout32++;
                    $display("out32 cyc=%0d tag=%0d data=0x%08h", cyc, ot32, od32);
                end
            end
            if (ov64 && or64) begin
                if (q64.size() == 0) begin
                    check("out64_unexpected", 64'(ot64), 64'hFFFF);
                end else begin
                    p = q64.pop_front();
                    check("out64_data", od64, p.data);
                    check("out64_tag", 64'(ot64), 64'(p.tag));
                    if (chk_lat) check("out64_latency", 64'(cyc - p.cyc), 64'd2);
`ifdef SHA2_SIGMA_PARITY_EN
                    check("out64_parity", 64'(op64), 64'(^p.data));
`endif
                    nout64++;
                    $display("out64 cyc=%0d tag=%0d data=0x%016h", cyc, ot64, od64);
                end
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drive32(input int i);
        iv32      = 1'b1;
        im32      = v32[i].mode;
        id32      = v32[i].data[31:0];
        it32      = v32[i].tag;
        exp32_cur = v32[i].exp;
    endtask

    task automatic drive64(input int i);
        iv64      = 1'b1;
        im64      = v64[i].mode;
        id64      = v64[i].data;
        it64      = v64[i].tag;
        exp64_cur = v64[i].exp;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        iv32 = 1'b0;
        iv64 = 1'b0;
        while ((q32.size() != 0 || q64.size() != 0) && n < budget) begin
            step();
            n++;
        end
        check("drain_pending", 64'(q32.size() + q64.size()), 64'd0);
    endtask

    initial begin
        v32[0] = '{2'd0, 64'h0000_0001, 4'd1, 64'h4008_0400};
        v32[1] = '{2'd1, 64'h0000_0001, 4'd2, 64'h0420_0080};
        v32[2] = '{2'd2, 64'h0000_0001, 4'd3, 64'h0200_4000};
        v32[3] = '{2'd3, 64'h0000_0001, 4'd4, 64'h0000_A000};
        v32[4] = '{2'd2, 64'h0000_0008, 4'd5, 64'h1002_0001};
        v32[5] = '{2'd3, 64'h8000_0000, 4'd6, 64'h0020_5000};
        v32[6] = '{2'd2, 64'hFFFF_FFFF, 4'd7, 64'h1FFF_FFFF};

        v64[0] = '{2'd0, 64'h0000_0000_0000_0001, 4'd8,  64'h0000_0010_4200_0000};
        v64[1] = '{2'd1, 64'h0000_0000_0000_0001, 4'd9,  64'h0004_4000_0080_0000};
        v64[2] = '{2'd2, 64'h0000_0000_0000_0001, 4'd10, 64'h8100_0000_0000_0000};
        v64[3] = '{2'd3, 64'h0000_0000_0000_0080, 4'd11, 64'h0010_0000_0000_0402};

        rst  = 1'b1;
        iv32 = 1'b0; im32 = '0; id32 = '0; it32 = '0; or32 = 1'b0;
        iv64 = 1'b0; im64 = '0; id64 = '0; it64 = '0; or64 = 1'b0;
        exp32_cur = '0;
        exp64_cur = '0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        check("rst_out_valid32", 64'(ov32), 64'd0);
        check("rst_out_data32", {32'b0, od32}, 64'd0);
        check("rst_out_tag32", 64'(ot32), 64'd0);
        check("rst_in_ready32", 64'(ir32), 64'd1);
        check("rst_out_valid64", 64'(ov64), 64'd0);
        check("rst_out_data64", od64, 64'd0);
`ifdef SHA2_SIGMA_PARITY_EN
        check("rst_out_parity32", 64'(op32), 64'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back mixed-mode stream, free-flowing output
        or32    = 1'b1;
        or64    = 1'b1;
        chk_lat = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive32(i);
            if (i < 4) drive64(i);
            else       iv64 = 1'b0;
            step();
        end
        drain(20);
        check("stream_count32", 64'(nout32), 64'd7);
        check("stream_count64", 64'(nout64), 64'd4);

        // Output stall with a full pipe
        chk_lat = 1'b0;
        nout32  = 0;
        or32    = 1'b0;
        drive32(0);
        step();
        drive32(1);
        step();
        drive32(2);
        for (int k = 0; k < 5; k++) begin
            #1;
            check("stall_in_ready", 64'(ir32), 64'd0);
            check("stall_out_valid", 64'(ov32), 64'd1);
            check("stall_out_data", {32'b0, od32}, v32[0].exp);
            check("stall_out_tag", 64'(ot32), 64'(v32[0].tag));
            step();
        end
        // Releasing the stall accepts operand 2 in the same cycle operand 0 leaves.
        or32 = 1'b1;
        #1;
        check("release_in_ready", 64'(ir32), 64'd1);
        step();
        drain(20);
        check("stall_count", 64'(nout32), 64'd3);

        // Reset with two operands in flight
        nout32 = 0;
        drive32(3);
        step();
        drive32(4);
        step();
        iv32 = 1'b0;
        or32 = 1'b0;
        #1;
        check("pre_rst_out_valid", 64'(ov32), 64'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 64'(ov32), 64'd0);
        check("mid_rst_in_ready", 64'(ir32), 64'd1);
        check("mid_rst_out_data", {32'b0, od32}, 64'd0);
        q32.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        or32    = 1'b1;
        chk_lat = 1'b1;
        drive32(5);
        step();
        drain(20);
        check("post_rst_count", 64'(nout32), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
